// File: rtl/csync_vsync_separator.sv
// Measures composite-sync low pulses and recovers a clean vertical sync level,
// an HSYNC strobe, a synchronized CSYNC copy and a signal-present flag.
module csync_vsync_separator #(
  parameter int SYNC_MIN    = 27,
  parameter int BROAD_MIN   = 270,
  parameter int BROAD_COUNT = 3,
  parameter int TIMEOUT     = 2700,
  parameter int CNT_W       = 12
) (
  input  logic clk_in,
  input  logic rst,
  input  logic csync_in,
  output logic csync_out,
  output logic vsync_out,
  output logic hsync_stb,
  output logic sync_ok
);

  localparam int BR_W = $clog2(BROAD_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] SYNC_MIN_C  = CNT_W'(SYNC_MIN);
  localparam logic [CNT_W-1:0] BROAD_MIN_C = CNT_W'(BROAD_MIN);
  localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT);
  localparam logic [BR_W-1:0]  BR_MAX      = BR_W'(BROAD_COUNT);

  typedef enum logic {V_IDLE, V_SYNC} vstate_e;

  logic            sync1_q, sync1_d;
  logic            cs_s_q, cs_s_d;
  logic            cs_prev_q, cs_prev_d;
  logic            csync_out_q, csync_out_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [BR_W-1:0] broad_run_q, broad_run_d;
  vstate_e         state_q, state_d;
  logic            hsync_stb_q, hsync_stb_d;
  logic            sync_ok_q, sync_ok_d;

  logic            rise;
  logic            valid_pulse;
  logic            broad_pulse;
  logic [BR_W-1:0] br_inc;

  always_comb begin
    sync1_d     = csync_in;
    cs_s_d      = sync1_q;
    cs_prev_d   = cs_s_q;
    // Parallel copy of the second synchronizer stage so the output can reset low
    // while the chain itself resets to the idle-high line level.
    csync_out_d = sync1_q;

    rise        = cs_s_q & ~cs_prev_q;
    valid_pulse = rise && (low_cnt_q >= SYNC_MIN_C);
    broad_pulse = rise && (low_cnt_q >= BROAD_MIN_C);

    low_cnt_d = low_cnt_q;
    if (rise) begin
      low_cnt_d = '0;
    end else if (!cs_s_q && (low_cnt_q != CNT_MAX)) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end

    idle_cnt_d = idle_cnt_q;
    if (valid_pulse) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != CNT_MAX) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    state_d     = state_q;
    broad_run_d = broad_run_q;
    hsync_stb_d = 1'b0;
    sync_ok_d   = sync_ok_q;
    br_inc      = (broad_run_q == BR_MAX) ? BR_MAX : broad_run_q + 1'b1;

    // A qualifying edge takes priority over a timeout landing in the same cycle.
    if (valid_pulse) begin
      sync_ok_d = 1'b1;
      if (broad_pulse) begin
        if (state_q == V_IDLE) begin
          broad_run_d = br_inc;
          if (br_inc == BR_MAX) begin
            state_d = V_SYNC;
          end
        end
      end else begin
        broad_run_d = '0;
        hsync_stb_d = 1'b1;
        state_d     = V_IDLE;
      end
    end else if (idle_cnt_q >= TIMEOUT_C) begin
      sync_ok_d   = 1'b0;
      state_d     = V_IDLE;
      broad_run_d = '0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      cs_s_q      <= 1'b1;
      cs_prev_q   <= 1'b1;
      csync_out_q <= 1'b0;
      low_cnt_q   <= '0;
      idle_cnt_q  <= '0;
      broad_run_q <= '0;
      state_q     <= V_IDLE;
      hsync_stb_q <= 1'b0;
      sync_ok_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      cs_s_q      <= cs_s_d;
      cs_prev_q   <= cs_prev_d;
      csync_out_q <= csync_out_d;
      low_cnt_q   <= low_cnt_d;
      idle_cnt_q  <= idle_cnt_d;
      broad_run_q <= broad_run_d;
      state_q     <= state_d;
      hsync_stb_q <= hsync_stb_d;
      sync_ok_q   <= sync_ok_d;
    end
  end

  assign csync_out = csync_out_q;
  assign vsync_out = (state_q != V_SYNC);
  assign hsync_stb = hsync_stb_q;
  assign sync_ok   = sync_ok_q;

endmodule

// File: tb/tb_csync_vsync_separator.sv
// Scoreboard bench: a pulse-level model predicts output events (kind and cycle),
// and a negedge monitor matches every observed output change against them.
module tb_csync_vsync_separator;

  logic clk_in = 1'b0;
  logic rst;
  logic csync_in;
  logic csync_out;
  logic vsync_out;
  logic hsync_stb;
  logic sync_ok;

  csync_vsync_separator dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .csync_in (csync_in),
    .csync_out(csync_out),
    .vsync_out(vsync_out),
    .hsync_stb(hsync_stb),
    .sync_ok  (sync_ok)
  );

  always #5 clk_in = ~clk_in;

  localparam int K_HS = 0;
  localparam int K_VF = 1;
  localparam int K_VR = 2;
  localparam int K_SR = 3;
  localparam int K_SF = 4;
  localparam int LOSS_DELAY = 2701;

  typedef struct {
    int t;
    int kind;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  bit  hist [131072];
  int  follow_start = 1 << 30;
  bit  mon_en = 1'b0;
  bit  prev_vs = 1'b1;
  bit  prev_so = 1'b0;

  bit  m_sok = 1'b0;
  bit  m_vs = 1'b1;
  int  m_br = 0;
  int  m_last = 0;

  always @(posedge clk_in) begin
    hist[cyc] <= csync_in;
    cyc <= cyc + 1;
  end

  function automatic void push_ev(int t, int k);
    ev_t e;
    e.t = t;
    e.kind = k;
    exp_q.push_back(e);
  endfunction

  // Loss of signal: 2701 cycles after the last valid pulse's output response,
  // unless a valid pulse responds in that very cycle.
  function automatic void advance(int t);
    if (m_sok && (m_last + LOSS_DELAY < t)) begin
      if (!m_vs) push_ev(m_last + LOSS_DELAY, K_VR);
      push_ev(m_last + LOSS_DELAY, K_SF);
      m_sok = 1'b0;
      m_vs = 1'b1;
      m_br = 0;
    end
  endfunction

  function automatic void model_pulse(int w, int t);
    advance(t);
    if (w >= 27) begin
      m_last = t;
      if (w < 270) begin
        push_ev(t, K_HS);
        if (!m_vs) begin
          push_ev(t, K_VR);
          m_vs = 1'b1;
        end
        m_br = 0;
      end else if (m_vs) begin
        if (m_br < 3) m_br = m_br + 1;
        if (m_br == 3) begin
          push_ev(t, K_VF);
          m_vs = 1'b0;
        end
      end
      if (!m_sok) begin
        push_ev(t, K_SR);
        m_sok = 1'b1;
      end
    end
  endfunction

  function automatic void check_output(int k);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL unexpected_event: got kind=%0d at cycle %0d, required no event", k, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.t != cyc || e.kind != k) begin
        failures++;
        $display("[TB] FAIL event_match: got kind=%0d at cycle %0d, required kind=%0d at cycle %0d",
                 k, cyc, e.kind, e.t);
      end
    end
  endfunction

  function automatic void check_val(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got %b, required %b at cycle %0d", name, act, req, cyc);
    end
  endfunction

  // Output monitor: any strobe cycle or level change is an event to be matched.
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (hsync_stb === 1'b1) check_output(K_HS);
      if (vsync_out !== prev_vs) check_output(vsync_out ? K_VR : K_VF);
      if (sync_ok !== prev_so) check_output(sync_ok ? K_SR : K_SF);
      prev_vs = vsync_out;
      prev_so = sync_ok;
      while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
        checks++;
        failures++;
        $display("[TB] FAIL missed_event: got nothing, required kind=%0d at cycle %0d",
                 exp_q[0].kind, exp_q[0].t);
        void'(exp_q.pop_front());
      end
      if (cyc >= follow_start && (cyc % 8) == 0) check_val("csync_out_follow", csync_out, hist[cyc-2]);
    end
  end

  // One low pulse of w cycles followed by gap high cycles; called on a negedge.
  task automatic apply_stimulus(input int w, input int gap);
    model_pulse(w, cyc + w + 3);
    csync_in = 1'b0;
    repeat (w) @(negedge clk_in);
    csync_in = 1'b1;
    advance(cyc + gap);
    repeat (gap) @(negedge clk_in);
  endtask

  task automatic idle_for(input int n);
    advance(cyc + n);
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    int w;
    int cat;
    rst = 1'b1;
    csync_in = 1'b0;
    @(posedge clk_in);
    repeat (4) begin
      @(negedge clk_in);
      check_val("reset_vsync_out", vsync_out, 1'b1);
      check_val("reset_hsync_stb", hsync_stb, 1'b0);
      check_val("reset_sync_ok", sync_ok, 1'b0);
      check_val("reset_csync_out", csync_out, 1'b0);
    end
    rst = 1'b0;
    follow_start = cyc + 2;
    prev_vs = 1'b1;
    prev_so = 1'b0;
    mon_en = 1'b1;
    // Line held low through reset forms a short glitch afterwards.
    repeat (10) @(negedge clk_in);
    csync_in = 1'b1;
    idle_for(100);

    for (int i = 0; i < 10; i++) apply_stimulus(127, 1601);

    for (int i = 0; i < 5; i++) apply_stimulus(63, 801);
    for (int i = 0; i < 5; i++) apply_stimulus(737, 127);
    for (int i = 0; i < 5; i++) apply_stimulus(63, 801);

    apply_stimulus(26, 500);
    apply_stimulus(27, 500);
    apply_stimulus(269, 500);
    apply_stimulus(270, 500);
    apply_stimulus(63, 500);
    apply_stimulus(300, 200);
    apply_stimulus(20, 200);
    apply_stimulus(300, 200);
    apply_stimulus(20, 200);
    apply_stimulus(300, 200);
    apply_stimulus(63, 500);

    apply_stimulus(300, 300);
    apply_stimulus(300, 300);
    apply_stimulus(63, 300);
    apply_stimulus(300, 300);
    apply_stimulus(300, 300);
    apply_stimulus(63, 500);

    apply_stimulus(63, 3000);
    apply_stimulus(63, 400);
    for (int i = 0; i < 3; i++) apply_stimulus(300, 300);
    apply_stimulus(3000, 500);
    apply_stimulus(63, 500);

    for (int i = 0; i < 20; i++) begin
      cat = $urandom_range(0, 2);
      if (cat == 0) w = $urandom_range(1, 26);
      else if (cat == 1) w = $urandom_range(27, 269);
      else w = $urandom_range(270, 900);
      apply_stimulus(w, $urandom_range(2, 1200));
    end

    idle_for(3000);
    repeat (20) @(negedge clk_in);
    mon_en = 1'b0;
    while (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL pending_event: got nothing, required kind=%0d at cycle %0d",
               exp_q[0].kind, exp_q[0].t);
      void'(exp_q.pop_front());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
